calc_seq_core: RTL and testbench

Parametrised, sequential successor to the TinyTapeout calculator datapath. It accepts one operation per valid/ready handshake and executes single-cycle logic/add ops. Multiply and divide run as iterative WIDTH-cycle operations. It holds the result and flags until the consumer accepts them. It sits between the `tt_um_*` top-level pin-mux/input sequencer and the output driver.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_muldiv_iter.sv | 136 +++++++++++++
 rtl/calc_seq_core.sv | 144 ++++++++++++++
 tb/tb_calc_seq_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode/state types and constants for the sequential calculator core.
// The optional divider is controlled by the CALC_DIV_EN macro in the files that import this package.
package calc_pkg;

  localparam int CALC_OP_W = 3;

  typedef enum logic [CALC_OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_DIV  = 3'd6,
    OP_RSVD = 3'd7
  } calc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } calc_state_e;

endpackage

// File: rtl/calc_muldiv_iter.sv
// calc_muldiv_iter: iterative shift-add multiplier / restoring divider, one bit per cycle.
// Both operations share one 2*WIDTH working register: for MUL it is {partial, multiplier},
// for DIV it is {remainder, quotient}. 'res' is the combinational value of the next step,
// so on the cycle 'done' is high it already holds the final answer.
// The divider half only exists when CALC_DIV_EN is defined.
module calc_muldiv_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res,
  output logic               div0
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_next;
  logic [WIDTH-1:0]   w_ld_opnd;
  logic [WIDTH-1:0]   w_ld_lo;

  // One shift-add step: add multiplicand to the upper half when the current multiplier bit is set, then shift right.
  always_comb begin
    w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};
  end

`ifdef CALC_DIV_EN
  logic               r_is_div;
  logic               r_div0;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_neg;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_unused_diff_bit;

  // One restoring-division step: shift the next dividend bit into the remainder and subtract the divisor if it fits.
  // With a zero divisor nothing is ever subtracted, which leaves remainder = a and quotient = all-ones.
  always_comb begin
    w_div_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    w_div_neg   = w_div_diff[WIDTH+1];
    if (w_div_neg) begin
      w_div_rem = w_div_shift[WIDTH-1:0];
    end else begin
      w_div_rem = w_div_diff[WIDTH-1:0];
    end
    w_div_next = {w_div_rem, r_p[WIDTH-2:0], ~w_div_neg};
  end

  // A successful subtraction always leaves a remainder below the divisor, so this bit is always zero.
  assign w_unused_diff_bit = w_div_diff[WIDTH];

  // Operand loading: the divisor is kept in r_opnd and the dividend starts in the low half.
  always_comb begin
    if (is_div) begin
      w_ld_opnd = b;
      w_ld_lo   = a;
    end else begin
      w_ld_opnd = a;
      w_ld_lo   = b;
    end
  end

  // Choose which datapath advances the working register.
  always_comb begin
    if (r_is_div) begin
      w_next = w_div_next;
    end else begin
      w_next = w_mul_next;
    end
  end

  // Remember the operation kind and divide-by-zero condition for the whole iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
    end else if (start) begin
      r_is_div <= is_div;
      r_div0   <= is_div && (b == {WIDTH{1'b0}});
    end
  end

  assign div0 = r_div0;
`else
  logic w_unused_is_div;

  assign w_unused_is_div = is_div;
  assign w_ld_opnd       = a;
  assign w_ld_lo         = b;
  assign w_next          = w_mul_next;
  assign div0            = 1'b0;
`endif

  // Iteration control: load operands on start, then advance exactly WIDTH steps; the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
      r_opnd <= {WIDTH{1'b0}};
      r_p    <= {(2*WIDTH){1'b0}};
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= {CNT_W{1'b0}};
      r_opnd <= w_ld_opnd;
      r_p    <= {{WIDTH{1'b0}}, w_ld_lo};
    end else if (r_busy) begin
      r_p <= w_next;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign done = r_busy && (r_cnt == CNT_LAST);
  assign res  = w_next;

endmodule

// File: rtl/calc_seq_core.sv
// calc_seq_core: sequential calculator with valid/ready handshakes on both sides.
// Logic/add ops complete in one cycle; MUL (and DIV when CALC_DIV_EN is defined) take WIDTH cycles.
// Result and flags are registered and held until the consumer accepts them.
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CALC_OP_W-1:0] op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 flag_err
);

  calc_state_e        r_state;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_result;
  logic               r_flag_zero;
  logic               r_flag_carry;
  logic               r_flag_err;

  logic               w_accept;
  logic               w_is_iter;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [2*WIDTH-1:0] w_alu_res;
  logic               w_alu_carry;
  logic               w_alu_err;
  logic               w_iter_done;
  logic [2*WIDTH-1:0] w_iter_res;
  logic               w_iter_div0;

  assign in_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

`ifdef CALC_DIV_EN
  assign w_is_iter = (op == OP_MUL) || (op == OP_DIV);
`else
  assign w_is_iter = (op == OP_MUL);
`endif

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

  // Single-cycle ALU; multi-cycle and reserved opcodes fall to the error default (only used when not iterative).
  always_comb begin
    w_alu_res   = {(2*WIDTH){1'b0}};
    w_alu_carry = 1'b0;
    w_alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res[WIDTH-1:0] = w_add[WIDTH-1:0];
        w_alu_carry          = w_add[WIDTH];
      end
      OP_SUB: begin
        w_alu_res[WIDTH-1:0] = w_sub[WIDTH-1:0];
        w_alu_carry          = w_sub[WIDTH];
      end
      OP_AND:  w_alu_res[WIDTH-1:0] = a & b;
      OP_OR:   w_alu_res[WIDTH-1:0] = a | b;
      OP_XOR:  w_alu_res[WIDTH-1:0] = a ^ b;
      default: w_alu_err = 1'b1;
    endcase
  end

  calc_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_accept && w_is_iter),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (w_iter_done),
    .res    (w_iter_res),
    .div0   (w_iter_div0)
  );

  // Control FSM and output registers; outputs only change when entering DONE, on handshake, or on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_out_valid  <= 1'b0;
      r_result     <= {(2*WIDTH){1'b0}};
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
      r_flag_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_iter) begin
              r_state <= ST_BUSY;
            end else begin
              r_state      <= ST_DONE;
              r_out_valid  <= 1'b1;
              r_result     <= w_alu_res;
              r_flag_zero  <= (w_alu_res == {(2*WIDTH){1'b0}});
              r_flag_carry <= w_alu_carry;
              r_flag_err   <= w_alu_err;
            end
          end
        end
        ST_BUSY: begin
          if (w_iter_done) begin
            r_state      <= ST_DONE;
            r_out_valid  <= 1'b1;
            r_result     <= w_iter_res;
            r_flag_zero  <= (w_iter_res == {(2*WIDTH){1'b0}});
            r_flag_carry <= 1'b0;
            r_flag_err   <= w_iter_div0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign flag_zero  = r_flag_zero;
  assign flag_carry = r_flag_carry;
  assign flag_err   = r_flag_err;

endmodule

// File: tb/tb_calc_seq_core.sv
// tb_calc_seq_core: directed self-checking bench for calc_seq_core at WIDTH=8.
// DIV expectations follow whether CALC_DIV_EN is defined for the build.
module tb_calc_seq_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_zero;
  logic        flag_carry;
  logic        flag_err;

  int n_checks = 0;
  int n_errors = 0;

  calc_seq_core #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_err   (flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one op for exactly one edge. Returns in cycle t+1.
  task automatic accept(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] er, input logic ec,
                           input logic ez, input logic ee);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_res"},   {16'd0, result},    {16'd0, er});
    check_eq({tag, "_carry"}, {31'd0, flag_carry}, {31'd0, ec});
    check_eq({tag, "_zero"},  {31'd0, flag_zero},  {31'd0, ez});
    check_eq({tag, "_err"},   {31'd0, flag_err},   {31'd0, ee});
  endtask

  task automatic run_single(input string tag, input logic [2:0] o, input logic [7:0] x,
                            input logic [7:0] y, input logic [15:0] er, input logic ec,
                            input logic ez, input logic ee);
    accept(o, x, y);
    check_out(tag, er, ec, ez, ee);
    check_eq({tag, "_rdy_busy"}, {31'd0, in_ready}, 32'd0);
    tick();
    check_eq({tag, "_valid_off"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_rdy_back"},  {31'd0, in_ready},  32'd1);
  endtask

  // Multi-cycle op; an ADD 1+1 request is driven mid-iteration and must be ignored.
  task automatic run_iter(input string tag, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [15:0] er, input logic ee);
    accept(o, x, y);
    for (int i = 1; i <= 8; i++) begin
      check_eq({tag, "_busy_valid"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, "_busy_rdy"},   {31'd0, in_ready},  32'd0);
      if (i == 2) begin
        in_valid = 1'b1;
        op       = 3'd0;
        a        = 8'd1;
        b        = 8'd1;
      end
      if (i == 5) begin
        in_valid = 1'b0;
      end
      tick();
    end
    check_out(tag, er, 1'b0, (er == 16'h0000), ee);
    tick();
    check_eq({tag, "_valid_off"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_held"},      {16'd0, result},    {16'd0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 8'd0;
    b         = 8'd0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result",    {16'd0, result},    32'd0);
    check_eq("rst_flags",     {29'd0, flag_zero, flag_carry, flag_err}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle ops
    run_single("add_200_100", 3'd0, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1'b0);
    run_single("sub_5_5",     3'd1, 8'd5,   8'd5,   16'h0000, 1'b0, 1'b1, 1'b0);
    run_single("sub_3_5",     3'd1, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0, 1'b0);
    run_single("add_ff_1",    3'd0, 8'hFF,  8'h01,  16'h0000, 1'b1, 1'b1, 1'b0);
    run_single("and",         3'd2, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1'b0);
    run_single("or",          3'd3, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1'b0, 1'b0);
    run_single("xor",         3'd4, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1'b0);
    run_single("rsvd",        3'd7, 8'h12,  8'h34,  16'h0000, 1'b0, 1'b1, 1'b1);

    // Multi-cycle ops
    run_iter("mul_ff_ff", 3'd5, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    run_iter("mul_0d_0b", 3'd5, 8'h0D, 8'h0B, 16'h008F, 1'b0);
    run_iter("mul_0_5",   3'd5, 8'h00, 8'h05, 16'h0000, 1'b0);
`ifdef CALC_DIV_EN
    run_iter("div_100_7", 3'd6, 8'd100, 8'd7, 16'h020E, 1'b0);
    run_iter("div_100_0", 3'd6, 8'd100, 8'd0, 16'h64FF, 1'b1);
    run_iter("div_7_100", 3'd6, 8'd7, 8'd100, 16'h0700, 1'b0);
`else
    run_single("div_off", 3'd6, 8'd100, 8'd7, 16'h0000, 1'b0, 1'b1, 1'b1);
`endif

    // Backpressure: result held for 5 cycles, new requests ignored
    out_ready = 1'b0;
    accept(3'd0, 8'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_res",   {16'd0, result},    32'h0002);
      check_eq("bp_rdy",   {31'd0, in_ready},  32'd0);
      if (i == 1) begin
        in_valid = 1'b1;
        op       = 3'd4;
        a        = 8'h55;
        b        = 8'h0F;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_rel_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bp_rel_rdy",   {31'd0, in_ready},  32'd1);
    check_eq("bp_rel_res",   {16'd0, result},    32'h0002);

    // Reset during a multiply aborts it
    accept(3'd5, 8'hFF, 8'hFF);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("abort_rdy_in_rst", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_res",   {16'd0, result},    32'd0);
    check_eq("abort_flags", {29'd0, flag_zero, flag_carry, flag_err}, 32'd0);
    check_eq("abort_rdy",   {31'd0, in_ready},  32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("abort_quiet", {31'd0, out_valid}, 32'd0);
    end

    // Core is usable after the abort
    run_single("post_abort_add", 3'd0, 8'd10, 8'd20, 16'h001E, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
